note_hit_judge: RTL and testbench

//   Consumer end of the random note stream. Accepts one 4-bit note (one bit per drum lane) from the

---
 rtl/note_hit_judge.sv | 111 +++++++++++
 tb/tb_note_hit_judge.sv | 398 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/note_hit_judge.sv
// note_hit_judge: accepts one 4-lane drum note, then judges the player's pad strikes
// inside a WINDOW-cycle timing window. Produces 1-cycle hit/miss pulses and keeps a
// saturating score and a saturating combo count.
module note_hit_judge #(
    parameter int WINDOW  = 16,  // cycles a note stays open for strikes (>=1)
    parameter int POINTS  = 10,  // score added per hit
    parameter int SCORE_W = 16   // width of score register
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               note_valid,
    input  logic [3:0]         note,
    input  logic [3:0]         pads,
    output logic               hit,
    output logic               miss,
    output logic               note_drop,
    output logic               busy,
    output logic [SCORE_W-1:0] score,
    output logic [7:0]         combo
);

    localparam int CNT_W = (WINDOW > 1) ? $clog2(WINDOW) : 1;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESULT
    } state_t;

    state_t             state;
    logic [3:0]         target;
    logic [3:0]         collected;
    logic [3:0]         pads_q;
    logic [CNT_W-1:0]   cnt;

    logic [3:0]         strike;
    logic               wrong;
    logic               done;
    logic [SCORE_W:0]   score_sum;

    // A strike is a rising pad level; a pad already high at acceptance never counts.
    assign strike    = pads & ~pads_q;
    assign wrong     = |(strike & ~target);
    assign done      = ((collected | strike) & target) == target;
    // One extra bit catches the carry so the score can clamp instead of wrapping.
    assign score_sum = {1'b0, score} + (SCORE_W + 1)'(POINTS);
    assign busy      = (state != IDLE);

    // Judge FSM with registered result pulses, score and combo bookkeeping.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            hit       <= 1'b0;
            miss      <= 1'b0;
            note_drop <= 1'b0;
            score     <= '0;
            combo     <= 8'd0;
            target    <= 4'h0;
            collected <= 4'h0;
            cnt       <= '0;
            pads_q    <= 4'hF;
        end else begin
            // NOTE: non-blocking assignments keep every register reading pre-edge values,
            // so pads_q here and the strike decode above never race each other.
            pads_q    <= pads;
            hit       <= 1'b0;
            miss      <= 1'b0;
            note_drop <= note_valid && (state != IDLE);

            case (state)
                IDLE: begin
                    if (note_valid && (note != 4'h0)) begin
                        target    <= note;
                        collected <= 4'h0;
                        cnt       <= CNT_W'(WINDOW - 1);
                        state     <= WAIT;
                    end
                end

                WAIT: begin
                    collected <= collected | (strike & target);
                    if (wrong) begin
                        miss  <= 1'b1;
                        combo <= 8'd0;
                        state <= RESULT;
                    end else if (done) begin
                        hit   <= 1'b1;
                        score <= score_sum[SCORE_W] ? {SCORE_W{1'b1}} : score_sum[SCORE_W-1:0];
                        combo <= (combo == 8'hFF) ? combo : combo + 8'd1;
                        state <= RESULT;
                    end else if (cnt == '0) begin
                        miss  <= 1'b1;
                        combo <= 8'd0;
                        state <= RESULT;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end

                RESULT: begin
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_note_hit_judge.sv
// Testbench for note_hit_judge: two instances (16-bit and 8-bit score) share the same
// stimulus; a scoreboard queue holds the expected result of every accepted note.
module tb_note_hit_judge;

    localparam int WINDOW = 16;
    localparam int POINTS = 10;

    logic        clk;
    logic        rst_n;
    logic        note_valid;
    logic [3:0]  note;
    logic [3:0]  pads;

    logic        hit_a, miss_a, drop_a, busy_a;
    logic [15:0] score_a;
    logic [7:0]  combo_a;
    logic        hit_b, miss_b, drop_b, busy_b;
    logic [7:0]  score_b;
    logic [7:0]  combo_b;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit          is_hit;
        logic [15:0] score_w;
        logic [7:0]  score_n;
        logic [7:0]  combo;
    } exp_t;

    exp_t sb[$];

    int m_score16;
    int m_score8;
    int m_combo;

    note_hit_judge #(.WINDOW(WINDOW), .POINTS(POINTS), .SCORE_W(16)) dut_a (
        .clk(clk), .rst_n(rst_n), .note_valid(note_valid), .note(note), .pads(pads),
        .hit(hit_a), .miss(miss_a), .note_drop(drop_a), .busy(busy_a),
        .score(score_a), .combo(combo_a)
    );

    note_hit_judge #(.WINDOW(WINDOW), .POINTS(POINTS), .SCORE_W(8)) dut_b (
        .clk(clk), .rst_n(rst_n), .note_valid(note_valid), .note(note), .pads(pads),
        .hit(hit_b), .miss(miss_b), .note_drop(drop_b), .busy(busy_b),
        .score(score_b), .combo(combo_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Result monitor: every hit/miss pulse must match the oldest queued expectation.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (hit_a || miss_a || hit_b || miss_b) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_result: hit=%b/%b miss=%b/%b, required no pulse",
                         hit_a, hit_b, miss_a, miss_b);
            end else begin
                e = sb.pop_front();
                if ({hit_a, miss_a, hit_b, miss_b} !== {e.is_hit, !e.is_hit, e.is_hit, !e.is_hit}) begin
                    errors++;
                    $display("FAIL result_kind: hit=%b/%b miss=%b/%b, required hit=%b miss=%b",
                             hit_a, hit_b, miss_a, miss_b, e.is_hit, !e.is_hit);
                end
                checks++;
                if (score_a !== e.score_w || score_b !== e.score_n) begin
                    errors++;
                    $display("FAIL score: got %0d/%0d, required %0d/%0d",
                             score_a, score_b, e.score_w, e.score_n);
                end
                checks++;
                if (combo_a !== e.combo || combo_b !== e.combo) begin
                    errors++;
                    $display("FAIL combo: got %0d/%0d, required %0d", combo_a, combo_b, e.combo);
                end
            end
        end
    end

    task automatic model_reset();
        m_score16 = 0;
        m_score8  = 0;
        m_combo   = 0;
    endtask

    // Advance the reference model and queue the expected outcome of the current note.
    task automatic expect_result(input bit is_hit);
        if (is_hit) begin
            m_score16 = (m_score16 + POINTS > 65535) ? 65535 : m_score16 + POINTS;
            m_score8  = (m_score8 + POINTS > 255) ? 255 : m_score8 + POINTS;
            m_combo   = (m_combo == 255) ? 255 : m_combo + 1;
        end else begin
            m_combo = 0;
        end
        sb.push_back('{is_hit, 16'(m_score16), 8'(m_score8), 8'(m_combo)});
    endtask

    // Present a note for one cycle; returns at the negedge after the acceptance edge.
    task automatic send_note(input logic [3:0] n);
        @(negedge clk);
        note_valid = 1'b1;
        note       = n;
        @(negedge clk);
        note_valid = 1'b0;
        note       = 4'h0;
    endtask

    // Raise pads for one sampled edge, then release.
    task automatic strike(input logic [3:0] mask);
        pads = mask;
        @(negedge clk);
        pads = 4'h0;
    endtask

    // Wait (bounded) for a hit or miss pulse; cyc = negedges waited.
    task automatic wait_result(output int cyc);
        cyc = 0;
        while (!(hit_a || miss_a) && cyc < WINDOW + 8) begin
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (!(hit_a || miss_a)) begin
            errors++;
            $display("FAIL result_timeout: no pulse after %0d cycles, required a pulse", cyc);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        model_reset();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        int cyc;
        rst_n      = 1'b0;
        note_valid = 1'b0;
        note       = 4'h0;
        pads       = 4'hF;
        model_reset();
        repeat (3) @(negedge clk);
        checks++;
        if ({hit_a, miss_a, drop_a, busy_a, hit_b, miss_b, drop_b, busy_b} !== 8'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b, required 00000000",
                     {hit_a, miss_a, drop_a, busy_a, hit_b, miss_b, drop_b, busy_b});
        end
        checks++;
        if (score_a !== 16'd0 || score_b !== 8'd0 || combo_a !== 8'd0 || combo_b !== 8'd0) begin
            errors++;
            $display("FAIL reset_counters: score=%0d/%0d combo=%0d/%0d, required 0",
                     score_a, score_b, combo_a, combo_b);
        end
        rst_n = 1'b1;
        // Pads held high straight through reset must not complete the note.
        send_note(4'b0001);
        expect_result(1'b0);
        wait_result(cyc);
        checks++;
        if (cyc !== WINDOW) begin
            errors++;
            $display("FAIL held_pad_timeout: miss after %0d cycles, required %0d", cyc, WINDOW);
        end
        pads = 4'h0;
    endtask

    task automatic test_hit_basic();
        send_note(4'b0101);
        expect_result(1'b1);
        checks++;
        if (busy_a !== 1'b1) begin
            errors++;
            $display("FAIL busy_wait: got %b, required 1", busy_a);
        end
        repeat (2) @(negedge clk);
        strike(4'b0101);
        checks++;
        if (hit_a !== 1'b1 || busy_a !== 1'b1) begin
            errors++;
            $display("FAIL hit_latency: hit=%b busy=%b, required 1 1", hit_a, busy_a);
        end
    endtask

    task automatic test_partial_and_wrong();
        int cyc;
        // Lanes struck separately inside the window.
        send_note(4'b0011);
        expect_result(1'b1);
        strike(4'b0001);
        @(negedge clk);
        strike(4'b0010);
        checks++;
        if (hit_a !== 1'b1) begin
            errors++;
            $display("FAIL split_hit: hit=%b, required 1", hit_a);
        end
        // Wrong lane.
        send_note(4'b0011);
        expect_result(1'b0);
        strike(4'b0100);
        checks++;
        if (miss_a !== 1'b1) begin
            errors++;
            $display("FAIL wrong_lane: miss=%b, required 1", miss_a);
        end
        // Completing and wrong strike on the same cycle.
        send_note(4'b0001);
        expect_result(1'b0);
        strike(4'b0011);
        checks++;
        if (miss_a !== 1'b1) begin
            errors++;
            $display("FAIL wrong_and_done: miss=%b, required 1", miss_a);
        end
        // Only part of the chord struck, window expires.
        send_note(4'b0011);
        expect_result(1'b0);
        strike(4'b0001);
        wait_result(cyc);
        checks++;
        if (cyc !== WINDOW - 1 || miss_a !== 1'b1) begin
            errors++;
            $display("FAIL partial_timeout: %0d cycles miss=%b, required %0d 1", cyc, miss_a, WINDOW - 1);
        end
    endtask

    task automatic test_window_edges();
        int cyc;
        // No strike at all.
        send_note(4'b1000);
        expect_result(1'b0);
        wait_result(cyc);
        checks++;
        if (cyc !== WINDOW) begin
            errors++;
            $display("FAIL timeout_latency: %0d cycles, required %0d", cyc, WINDOW);
        end
        // Strike sampled on the first window cycle.
        send_note(4'b0010);
        expect_result(1'b1);
        strike(4'b0010);
        checks++;
        if (hit_a !== 1'b1) begin
            errors++;
            $display("FAIL first_cycle_hit: hit=%b, required 1", hit_a);
        end
        // Strike sampled on the last window cycle.
        send_note(4'b0010);
        expect_result(1'b1);
        repeat (WINDOW - 1) @(negedge clk);
        strike(4'b0010);
        checks++;
        if (hit_a !== 1'b1) begin
            errors++;
            $display("FAIL last_cycle_hit: hit=%b, required 1", hit_a);
        end
        // Pad rising on the acceptance edge is an IDLE strike and is ignored.
        @(negedge clk);
        note_valid = 1'b1;
        note       = 4'b0100;
        pads       = 4'b0100;
        @(negedge clk);
        note_valid = 1'b0;
        note       = 4'h0;
        expect_result(1'b0);
        wait_result(cyc);
        checks++;
        if (cyc !== WINDOW) begin
            errors++;
            $display("FAIL idle_strike_ignored: miss after %0d cycles, required %0d", cyc, WINDOW);
        end
        pads = 4'h0;
    endtask

    task automatic test_drop_and_rest();
        send_note(4'b0100);
        expect_result(1'b1);
        note_valid = 1'b1;
        note       = 4'b0010;
        @(negedge clk);
        note_valid = 1'b0;
        note       = 4'h0;
        checks++;
        if (drop_a !== 1'b1 || drop_b !== 1'b1 || busy_a !== 1'b1) begin
            errors++;
            $display("FAIL drop_in_wait: drop=%b/%b busy=%b, required 1 1 1", drop_a, drop_b, busy_a);
        end
        strike(4'b0100);
        checks++;
        if (drop_a !== 1'b0 || hit_a !== 1'b1) begin
            errors++;
            $display("FAIL drop_pulse_width: drop=%b hit=%b, required 0 1", drop_a, hit_a);
        end
        // Note offered during RESULT is discarded too.
        note_valid = 1'b1;
        note       = 4'b1111;
        @(negedge clk);
        note_valid = 1'b0;
        note       = 4'h0;
        checks++;
        if (drop_a !== 1'b1 || busy_a !== 1'b0) begin
            errors++;
            $display("FAIL drop_in_result: drop=%b busy=%b, required 1 0", drop_a, busy_a);
        end
        @(negedge clk);
        checks++;
        if (drop_a !== 1'b0 || busy_a !== 1'b0) begin
            errors++;
            $display("FAIL dropped_not_accepted: drop=%b busy=%b, required 0 0", drop_a, busy_a);
        end
        // Rest note in IDLE.
        note_valid = 1'b1;
        note       = 4'h0;
        @(negedge clk);
        note_valid = 1'b0;
        checks++;
        if (busy_a !== 1'b0 || drop_a !== 1'b0) begin
            errors++;
            $display("FAIL rest_note: busy=%b drop=%b, required 0 0", busy_a, drop_a);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int i = 0; i < 260; i++) begin
            send_note(4'b0001);
            expect_result(1'b1);
            strike(4'b0001);
            if (i == 25) begin
                checks++;
                if (score_b !== 8'd255 || score_a !== 16'd260 || combo_a !== 8'd26) begin
                    errors++;
                    $display("FAIL saturate_26: score=%0d/%0d combo=%0d, required 260/255 26",
                             score_a, score_b, combo_a);
                end
            end
        end
        @(negedge clk);
        checks++;
        if (score_a !== 16'd2600 || score_b !== 8'd255 || combo_a !== 8'd255 || combo_b !== 8'd255) begin
            errors++;
            $display("FAIL saturate_260: score=%0d/%0d combo=%0d/%0d, required 2600/255 255",
                     score_a, score_b, combo_a, combo_b);
        end
    endtask

    task automatic test_reset_mid_note();
        send_note(4'b0001);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        model_reset();
        checks++;
        if ({hit_a, miss_a, busy_a, hit_b, miss_b, busy_b} !== 6'b0 ||
            score_a !== 16'd0 || score_b !== 8'd0 || combo_a !== 8'd0 || combo_b !== 8'd0) begin
            errors++;
            $display("FAIL reset_mid_note: hit=%b miss=%b busy=%b score=%0d/%0d combo=%0d, required all 0",
                     hit_a, miss_a, busy_a, score_a, score_b, combo_a);
        end
        rst_n = 1'b1;
        // Abandoned note must never produce a pulse (the monitor flags any).
        repeat (WINDOW + 4) @(negedge clk);
        send_note(4'b1001);
        expect_result(1'b1);
        strike(4'b1001);
        checks++;
        if (hit_a !== 1'b1 || score_a !== 16'd10 || combo_a !== 8'd1) begin
            errors++;
            $display("FAIL after_reset_hit: hit=%b score=%0d combo=%0d, required 1 10 1",
                     hit_a, score_a, combo_a);
        end
    endtask

    initial begin
        test_reset();
        test_hit_basic();
        test_partial_and_wrong();
        test_window_edges();
        test_drop_and_rest();
        test_back_to_back();
        test_reset_mid_note();
        repeat (3) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL pending_results: %0d outstanding, required 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
